// File: rtl/fnd_multi_scan_if.sv
// Host-side bundle for the multiplexed FND driver: value/mode/strobe in,
// status and scanned digit pins out.
interface fnd_multi_scan_if #(
  parameter int DIGITS = 4,
  parameter int DATA_W = 14
);
  logic [DATA_W-1:0] iValue;
  logic              iLoad;
  logic              display_mode;
  logic              iBlankLZ;
  logic              oBusy;
  logic              oOverflow;
  logic [DIGITS-1:0] oSel;
  logic [6:0]        oSeg;

  modport master (
    output iValue, iLoad, display_mode, iBlankLZ,
    input  oBusy, oOverflow, oSel, oSeg
  );

  modport slave (
    input  iValue, iLoad, display_mode, iBlankLZ,
    output oBusy, oOverflow, oSel, oSeg
  );
endinterface

// File: rtl/fnd_multi_scan.sv
// Multiplexed DIGITS-digit 7-segment driver with hex/decimal display,
// sequential double-dabble conversion, leading-zero blanking and atomic commit.
//
// state  | meaning
// IDLE   | waiting for iLoad; display holds last committed content
// CONV   | one shift-add-3 step per cycle, DATA_W cycles total
// COMMIT | all digit codes and overflow written in one cycle
module fnd_multi_scan #(
  parameter int DIGITS   = 4,
  parameter int DATA_W   = 14,
  parameter int SCAN_DIV = 50000
) (
  input logic              iCLK,
  input logic              inReset,
  fnd_multi_scan_if.slave  bus
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int IDX_W  = $clog2(DIGITS);
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int EXT_W  = (DATA_W > BCD_W) ? DATA_W : BCD_W;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t                  r_state;
  logic [DATA_W-1:0]       r_val;
  logic                    r_hex;
  logic                    r_blz;
  logic [BCD_W-1:0]        r_bcd;
  logic                    r_cout;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_busy;
  logic                    r_ovf;
  logic [DIGITS-1:0][6:0]  r_disp;
  logic [SCAN_W-1:0]       r_scan;
  logic [IDX_W-1:0]        r_idx;
  logic [DIGITS-1:0]       r_sel;
  logic [6:0]              r_seg;

  logic [BCD_W-1:0]        w_bcd_adj;
  logic [EXT_W-1:0]        w_ext;
  logic [BCD_W-1:0]        w_nib_src;
  logic                    w_ovf;
  logic [DIGITS-1:0][6:0]  w_codes;
  logic [DIGITS-1:0][6:0]  w_disp_next;
  logic                    w_tc;
  logic [IDX_W-1:0]        w_idx_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_decode = 7'h3F;
      4'h1: seg_decode = 7'h06;
      4'h2: seg_decode = 7'h5B;
      4'h3: seg_decode = 7'h4F;
      4'h4: seg_decode = 7'h66;
      4'h5: seg_decode = 7'h6D;
      4'h6: seg_decode = 7'h7D;
      4'h7: seg_decode = 7'h07;
      4'h8: seg_decode = 7'h7F;
      4'h9: seg_decode = 7'h6F;
      4'hA: seg_decode = 7'h77;
      4'hB: seg_decode = 7'h7C;
      4'hC: seg_decode = 7'h39;
      4'hD: seg_decode = 7'h5E;
      4'hE: seg_decode = 7'h79;
      default: seg_decode = 7'h71;
    endcase
  endfunction

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  // Hex overflow is any set bit above the displayable nibbles; decimal overflow
  // is the sticky carry shifted out of the top BCD digit.
  assign w_ext     = EXT_W'(r_val);
  assign w_nib_src = r_hex ? w_ext[BCD_W-1:0] : r_bcd;
  assign w_ovf     = r_hex ? |(w_ext >> BCD_W) : r_cout;

  always_comb begin
    logic       lead;
    logic [3:0] nib;
    w_codes = '0;
    lead    = 1'b1;
    nib     = 4'h0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nib = w_nib_src[4*k +: 4];
      if (w_ovf)                                   w_codes[k] = 7'h40;
      else if (r_blz && lead && nib == 4'h0 && k != 0) w_codes[k] = 7'h00;
      else                                         w_codes[k] = seg_decode(nib);
      if (nib != 4'h0) lead = 1'b0;
    end
  end

  assign w_disp_next = (r_state == COMMIT) ? w_codes : r_disp;
  assign w_tc        = (r_scan == SCAN_W'(SCAN_DIV - 1));

  always_comb begin
    w_idx_next = r_idx;
    if (w_tc) w_idx_next = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
  end

  always_ff @(posedge iCLK or negedge inReset) begin
    if (!inReset) begin
      r_state <= IDLE;
      r_val   <= '0;
      r_hex   <= 1'b0;
      r_blz   <= 1'b0;
      r_bcd   <= '0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.iLoad) begin
            r_val  <= bus.iValue;
            r_hex  <= bus.display_mode;
            r_blz  <= bus.iBlankLZ;
            r_bcd  <= '0;
            r_cout <= 1'b0;
            r_cnt  <= CNT_W'(DATA_W - 1);
            if (bus.display_mode) begin
              r_state <= COMMIT;
            end else begin
              r_state <= CONV;
              r_busy  <= 1'b1;
            end
          end
        end
        CONV: begin
          r_bcd  <= {w_bcd_adj[BCD_W-2:0], r_val[DATA_W-1]};
          r_cout <= r_cout | w_bcd_adj[BCD_W-1];
          r_val  <= r_val << 1;
          if (r_cnt == '0) begin
            r_state <= COMMIT;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        COMMIT: begin
          r_ovf   <= w_ovf;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Scan timing is independent of the FSM; a commit only changes what oSeg shows.
  always_ff @(posedge iCLK or negedge inReset) begin
    if (!inReset) begin
      r_disp <= '0;
      r_scan <= '0;
      r_idx  <= '0;
      r_sel  <= DIGITS'(1);
      r_seg  <= 7'h00;
    end else begin
      r_disp <= w_disp_next;
      r_scan <= w_tc ? '0 : r_scan + 1'b1;
      r_idx  <= w_idx_next;
      r_sel  <= DIGITS'(1) << w_idx_next;
      r_seg  <= w_disp_next[w_idx_next];
    end
  end

  assign bus.oBusy     = r_busy;
  assign bus.oOverflow = r_ovf;
  assign bus.oSel      = r_sel;
  assign bus.oSeg      = r_seg;

endmodule

// File: tb/tb_fnd_multi_scan.sv
// Directed bench for fnd_multi_scan: expected displays are queued at each load
// and popped when the commit edge is reached, then swept across the scan.
module tb_fnd_multi_scan;
  localparam int D  = 4;
  localparam int W  = 14;
  localparam int SD = 4;

  typedef struct packed {
    logic [D-1:0][6:0] seg;
    logic              ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];
  exp_t cur;

  fnd_multi_scan_if #(.DIGITS(D), .DATA_W(W)) bus ();

  fnd_multi_scan #(.DIGITS(D), .DATA_W(W), .SCAN_DIV(SD)) dut (
    .iCLK    (clk),
    .inReset (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] dec7(input int unsigned n);
    case (n)
      0: dec7 = 7'h3F;  1: dec7 = 7'h06;  2: dec7 = 7'h5B;  3: dec7 = 7'h4F;
      4: dec7 = 7'h66;  5: dec7 = 7'h6D;  6: dec7 = 7'h7D;  7: dec7 = 7'h07;
      8: dec7 = 7'h7F;  9: dec7 = 7'h6F;  10: dec7 = 7'h77; 11: dec7 = 7'h7C;
      12: dec7 = 7'h39; 13: dec7 = 7'h5E; 14: dec7 = 7'h79; default: dec7 = 7'h71;
    endcase
  endfunction

  function automatic exp_t model(input int unsigned v, input bit hex, input bit blz);
    exp_t        m;
    int unsigned base, lim, tmp;
    int unsigned d[D];
    int          msd;
    base = hex ? 16 : 10;
    lim  = 1;
    for (int k = 0; k < D; k++) lim = lim * base;
    tmp = v;
    msd = 0;
    for (int k = 0; k < D; k++) begin
      d[k] = tmp % base;
      tmp  = tmp / base;
      if (d[k] != 0) msd = k;
    end
    m.ovf = (v >= lim);
    for (int k = 0; k < D; k++)
      m.seg[k] = m.ovf ? 7'h40 : ((blz && k > msd) ? 7'h00 : dec7(d[k]));
    return m;
  endfunction

  function automatic int sel_idx(input logic [D-1:0] s);
    sel_idx = 0;
    for (int k = D - 1; k >= 0; k--) if (s[k]) sel_idx = k;
  endfunction

  task automatic sweep(input exp_t e, input string tag);
    for (int i = 0; i < SD * D; i++) begin
      chk({tag, "_sel_onehot"}, $countones(bus.oSel), 1);
      chk({tag, "_seg"}, bus.oSeg, e.seg[sel_idx(bus.oSel)]);
      @(negedge clk);
    end
    chk({tag, "_ovf"}, bus.oOverflow, e.ovf);
  endtask

  task automatic load(input int unsigned v, input bit hex, input bit blz);
    @(negedge clk);
    bus.iValue       = W'(v);
    bus.display_mode = hex;
    bus.iBlankLZ     = blz;
    bus.iLoad        = 1'b1;
    @(negedge clk);
    bus.iLoad        = 1'b0;
  endtask

  task automatic do_hex(input int unsigned v, input bit blz, input string tag);
    exp_t e;
    sb.push_back(model(v, 1'b1, blz));
    load(v, 1'b1, blz);
    chk({tag, "_busy0"}, bus.oBusy, 1'b0);
    chk({tag, "_old_seg"}, bus.oSeg, cur.seg[sel_idx(bus.oSel)]);
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, "_busy1"}, bus.oBusy, 1'b0);
    chk({tag, "_new_seg"}, bus.oSeg, e.seg[sel_idx(bus.oSel)]);
    cur = e;
    sweep(cur, tag);
  endtask

  task automatic do_dec(input int unsigned v, input bit blz, input int inj_at,
                        input int unsigned inj_v, input string tag);
    exp_t e;
    int   n;
    sb.push_back(model(v, 1'b0, blz));
    load(v, 1'b0, blz);
    n = 0;
    while (bus.oBusy && n < 64) begin
      n++;
      if (inj_at != 0 && n == inj_at) begin
        bus.iValue       = W'(inj_v);
        bus.display_mode = 1'b0;
        bus.iLoad        = 1'b1;
      end else begin
        bus.iLoad = 1'b0;
      end
      @(negedge clk);
    end
    bus.iLoad = 1'b0;
    chk({tag, "_busy_cycles"}, n, W);
    chk({tag, "_old_seg"}, bus.oSeg, cur.seg[sel_idx(bus.oSel)]);
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, "_new_seg"}, bus.oSeg, e.seg[sel_idx(bus.oSel)]);
    cur = e;
    sweep(cur, tag);
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    cur              = '0;
    bus.iValue       = '0;
    bus.iLoad        = 1'b0;
    bus.display_mode = 1'b0;
    bus.iBlankLZ     = 1'b0;
    rst_n            = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sel", bus.oSel, 4'b0001);
    chk("rst_seg", bus.oSeg, 7'h00);
    chk("rst_busy", bus.oBusy, 1'b0);
    chk("rst_ovf", bus.oOverflow, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i <= 4 * SD; i++) begin
      chk("scan_sel", bus.oSel, 4'b0001 << ((i / SD) % D));
      chk("scan_seg_blank", bus.oSeg, 7'h00);
      @(negedge clk);
    end

    do_hex(32'h02A5, 1'b0, "hex02A5");
    do_dec(9999, 1'b0, 0, 0, "dec9999");
    do_dec(10000, 1'b0, 0, 0, "dec10000");
    do_hex(32'h0001, 1'b0, "hex0001");
    do_dec(7, 1'b1, 0, 0, "dec7_blz");
    do_dec(0, 1'b1, 0, 0, "dec0_blz");
    do_hex(32'h3ABC, 1'b1, "hex3ABC_ovf");
    do_hex(32'h00F0, 1'b1, "hex00F0_blz");
    do_dec(1234, 1'b0, 5, 5678, "dec1234_ign");

    // Reset mid-conversion: the pending result must never appear.
    sb.push_back(model(4321, 1'b0, 1'b0));
    load(4321, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    chk("abort_busy_pre", bus.oBusy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.oBusy, 1'b0);
    chk("abort_sel", bus.oSel, 4'b0001);
    chk("abort_seg", bus.oSeg, 7'h00);
    chk("abort_ovf", bus.oOverflow, 1'b0);
    #1 rst_n = 1'b1;
    sb.delete();
    cur = '0;
    repeat (W + 4) @(negedge clk);
    chk("abort_busy_after", bus.oBusy, 1'b0);
    sweep(cur, "abort_blank");

    do_dec(1234, 1'b0, 0, 0, "dec1234_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
